// File: rtl/lpf_pkg.sv
// lpf_pkg: shared types, default coefficient table and saturation helper for lpf_fir_mc
package lpf_pkg;
  typedef enum logic {IDLE, SWEEP} lpf_state_e;
  // Symmetric window: 0x51 at both ends, then rising 0x07 -> 0x0E toward the centre.
  function automatic logic [7:0] lpf_default_coef(input int i, input int taps = 72);
    int m;
    int half;
    m = i < taps / 2 ? i : taps - 1 - i;
    half = taps / 2 > 1 ? taps / 2 - 1 : 1;
    return m == 0 ? 8'h51 : 8'(7 + (m * 7) / half);
  endfunction
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int msb);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< msb) - 64'sd1;
    lo = -(64'sd1 <<< msb);
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/lpf_coef_ram.sv
// lpf_coef_ram: 1W/1R synchronous-read coefficient RAM, power-up contents from the default table
module lpf_coef_ram
  import lpf_pkg::*;
#(
  parameter int TAPS   = 72,
  parameter int COEF_W = 8,
  parameter int AW     = $clog2(TAPS)
) (
  input  logic              CLK,
  input  logic              WE,
  input  logic [AW-1:0]     WADDR,
  input  logic [COEF_W-1:0] WDATA,
  input  logic [AW-1:0]     RADDR,
  output logic [COEF_W-1:0] RDATA
);
  typedef logic [COEF_W-1:0] mem_t [TAPS];
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < TAPS; i++) m[i] = COEF_W'(lpf_default_coef(i, TAPS));
    return m;
  endfunction
  mem_t mem = init_mem();
  always_ff @(posedge CLK) begin
    if (WE) mem[WADDR] <= WDATA;
    RDATA <= mem[RADDR];
  end
endmodule

// File: rtl/lpf_fir_mc.sv
// lpf_fir_mc: multi-channel windowed-FIR low-pass decimator sharing one multiplier across channels
module lpf_fir_mc
  import lpf_pkg::*;
#(
  parameter int MSB      = 15,
  parameter int CHANNELS = 2,
  parameter int TAPS     = 72,
  parameter int COEF_W   = 8,
  parameter int SHIFT    = 10
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         CE,
  input  logic                         ENABLE,
  input  logic                         SYNC,
  input  logic [CHANNELS*(MSB+1)-1:0]  IDATA,
  output logic [CHANNELS*(MSB+1)-1:0]  ODATA,
  output logic                         OVALID,
  output logic                         OVERRUN,
  input  logic                         COEF_WE,
  input  logic [$clog2(TAPS)-1:0]      COEF_ADDR,
  input  logic [COEF_W-1:0]            COEF_DATA
);
  localparam int W      = MSB + 1;
  localparam int PROD_W = MSB + COEF_W + 2;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  localparam int AW     = $clog2(TAPS);
  localparam int CW     = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  lpf_state_e state, state_nxt;
  logic [AW-1:0] tap;
  logic [CW-1:0] ch;
  logic fin, en_q, last_ch, accept;
  logic [COEF_W-1:0] coef;
  logic signed [MSB:0] smp [CHANNELS];
  logic signed [MSB:0] out [CHANNELS];
  logic signed [ACC_W-1:0] acc [CHANNELS];
  logic signed [PROD_W-1:0] prod;
  // Restart paths address tap 0 so a CE accepted alongside SYNC sees the right coefficient.
  lpf_coef_ram #(.TAPS(TAPS), .COEF_W(COEF_W)) u_ram (
    .CLK  (CLK),
    .WE   (COEF_WE),
    .WADDR(COEF_ADDR),
    .WDATA(COEF_DATA),
    .RADDR(RESET || SYNC ? '0 : tap),
    .RDATA(coef)
  );
  always_comb begin
    last_ch   = ch == CW'(CHANNELS - 1);
    accept    = CE && (state == IDLE || SYNC);
    state_nxt = accept ? SWEEP : (SYNC || (state == SWEEP && last_ch)) ? IDLE : state;
    prod      = PROD_W'($signed({1'b0, coef})) * PROD_W'(smp[ch]);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      tap     <= '0;
      ch      <= '0;
      fin     <= 1'b0;
      OVALID  <= 1'b0;
      OVERRUN <= 1'b0;
      en_q    <= 1'b1;
      for (int k = 0; k < CHANNELS; k++) begin
        acc[k] <= '0;
        out[k] <= '0;
      end
    end else begin
      state  <= state_nxt;
      OVALID <= fin && !SYNC;
      fin    <= 1'b0;
      if (CE && !accept) OVERRUN <= 1'b1;
      if (accept) begin
        ch <= '0;
        for (int k = 0; k < CHANNELS; k++) smp[k] <= IDATA[k*W +: W];
      end else if (state == SWEEP) ch <= ch + CW'(1);
      if (fin && !SYNC) begin
        en_q <= ENABLE;
        for (int k = 0; k < CHANNELS; k++) begin
          out[k] <= W'(sat(64'(acc[k] >>> SHIFT), MSB));
          acc[k] <= '0;
        end
      end
      if (SYNC) begin
        tap <= '0;
        for (int k = 0; k < CHANNELS; k++) acc[k] <= '0;
      end else if (state == SWEEP) begin
        acc[ch] <= acc[ch] + ACC_W'(prod);
        if (last_ch) begin
          tap <= tap == AW'(TAPS - 1) ? '0 : tap + AW'(1);
          fin <= tap == AW'(TAPS - 1);
        end
      end
    end
  end
  for (genvar k = 0; k < CHANNELS; k++) begin : g_out
    assign ODATA[k*W +: W] = en_q ? out[k] : IDATA[k*W +: W];
  end
endmodule
